// File: rtl/reg_bus_master_if.sv
// Bundle of the command/response handshake and register-bus signals of reg_bus_master.
// cmd_*/rsp_* use valid/ready: a beat moves on a rising edge where valid & ready are both high.
interface reg_bus_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_wen;
  logic                  bus_ren;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ready;

  // The initiator side.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  bus_rdata, bus_ready,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output bus_addr, bus_wdata, bus_wen, bus_ren
  );

  // The environment: command source, response sink and register slave.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready,
    output bus_rdata, bus_ready,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  bus_addr, bus_wdata, bus_wen, bus_ren
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register-bus initiator: one command at a time becomes a SETUP/ACCESS transfer and one response.
// Misaligned addresses are answered with an error and never reach the bus.
module reg_bus_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  reg_bus_master_if.master bus,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t           state;
  logic             wr_q;
  logic [CNT_W-1:0] cnt;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_q          <= 1'b0;
      cnt           <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wen   <= 1'b0;
      bus.bus_ren   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            wr_q          <= bus.cmd_write;
            if (bus.cmd_addr[1:0] != 2'b00) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
              state         <= RESP;
            end else begin
              // The bus address/data registers double as the captured command.
              bus.bus_addr  <= bus.cmd_addr;
              bus.bus_wdata <= bus.cmd_wdata;
              cnt           <= '0;
              state         <= SETUP;
            end
          end
        end

        SETUP: begin
          bus.bus_wen <= wr_q;
          bus.bus_ren <= !wr_q;
          state       <= ACCESS;
        end

        ACCESS: begin
          if (bus.bus_ready) begin
            bus.bus_wen   <= 1'b0;
            bus.bus_ren   <= 1'b0;
            bus.rsp_rdata <= wr_q ? '0 : bus.bus_rdata;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (TIMEOUT > 0) begin
            if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_W'(1);
            end
            // This stalled cycle is the TIMEOUT-th one: abort.
            if (cnt == CNT_MAX - CNT_W'(1)) begin
              bus.bus_wen   <= 1'b0;
              bus.bus_ren   <= 1'b0;
              bus.rsp_rdata <= '0;
              bus.rsp_err   <= 1'b1;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Register-bus initiator that drives the CTRL/STATUS register slave of the PWM block. It turns single-beat command requests (valid/ready) into two-phase SETUP/ACCESS transfers on the addr/wdata/wen/ren bus, captures read data and returns one response per command. It sits between a host-side sequencer (test controller, CPU shim) and the PWM register interface.

## Interface
Parameters:
- ADDR_WIDTH, 8, bus address width
- DATA_WIDTH, 32, bus data width
- TIMEOUT, 16, max ACCESS cycles waiting for bus_ready before abort; 0 disables timeout

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  1 = misaligned address or timeout
- bus_addr  out  ADDR_WIDTH  register address
- bus_wdata  out  DATA_WIDTH  register write data
- bus_wen  out  1  write enable
- bus_ren  out  1  read enable
- bus_rdata  in  DATA_WIDTH  register read data (combinational from slave)
- bus_ready  in  1  slave completes access this cycle; tie 1 for zero-wait slaves

## Operation
- Reset values: cmd_ready 0 during reset then 1 in IDLE; rsp_valid 0, rsp_rdata 0, rsp_err 0, bus_addr 0, bus_wdata 0, bus_wen 0, bus_ren 0; state IDLE; timeout counter 0.
- FSM states IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On handshake, register write/addr/wdata. If cmd_addr[1:0]!=0 -> RESP with rsp_err=1, no bus activity. Else -> SETUP.
- SETUP (1 cycle): bus_addr/bus_wdata driven from registered command, wen=ren=0. -> ACCESS.
- ACCESS: bus_addr/bus_wdata held; bus_wen=write, bus_ren=!write. If bus_ready=1: capture bus_rdata (reads) into rsp_rdata, rsp_err=0, -> RESP. If bus_ready=0: increment counter; when counter reaches TIMEOUT (TIMEOUT>0) -> RESP with rsp_err=1, rsp_rdata=0.
- RESP: rsp_valid=1, bus_wen=bus_ren=0, bus_addr/bus_wdata hold last value. On rsp_ready=1 -> IDLE, rsp_valid falls next cycle. rsp_rdata/rsp_err stable while rsp_valid=1.
- Writes: rsp_rdata=0. Write with bus_ready low holds bus_wen high over several cycles; slave writes are idempotent, acceptable.
- Counter cleared on entry to SETUP; width clog2(TIMEOUT+1), saturates never exceeds TIMEOUT.
- One outstanding command; cmd_ready=0 in SETUP, ACCESS, RESP.
- Reset mid-operation: immediate return to IDLE, enables drop asynchronously, pending command dropped, no response issued.

## Timing
- Handshake at edge N (IDLE) -> SETUP cycle N+1 -> ACCESS cycle N+2 -> with bus_ready=1, rsp_valid=1 in cycle N+3.
- Accept-to-response latency 3 cycles + wait cycles; misaligned: 1 cycle.
- Exactly one ACCESS cycle with wen/ren high when bus_ready=1.
- Back-to-back with rsp_ready held 1: IDLE re-entered N+4, next accept N+4; 4-cycle issue interval.
- Timeout: rsp_valid in cycle N+2+TIMEOUT+... i.e. first RESP cycle after TIMEOUT ACCESS cycles with bus_ready=0.
- cmd_* inputs sampled only at handshake; changes afterwards ignored.

## Test plan
- Write 0xA5A5_0001 to 0x00 with reg_if-style slave, bus_ready=1 -> bus_wen high exactly one cycle at N+2, bus_addr 0x00; rsp_valid at N+3, rsp_err=0, rsp_rdata=0; slave CTRL reads back 0xA5A5_0001.
- Read 0x04 with slave STATUS=0x0000_0003 -> bus_ren one cycle, rsp_rdata=0x3, rsp_err=0, latency 3.
- Read 0x02 -> no wen/ren ever asserted, rsp_valid next cycle, rsp_err=1, rsp_rdata=0.
- bus_ready held 0, TIMEOUT=16 -> 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, enables low; bus_ready=1 after 3 wait cycles -> normal response at N+6.
- rsp_ready low for 5 cycles then high; cmd_valid held throughout -> response stable, cmd_ready 0 until IDLE, second command accepted the cycle IDLE returns.
- Assert reset_n low during ACCESS -> bus_wen/bus_ren/rsp_valid 0 immediately; after release cmd_ready=1, no stale response.
